// File: rtl/wired_div_pkg.sv
// Shared MDU divider types: operation encoding, FSM states and the fixed result latency.
package wired_div_pkg;

  typedef enum logic [1:0] {
    DIV_W  = 2'b00,
    MOD_W  = 2'b01,
    DIV_WU = 2'b10,
    MOD_WU = 2'b11
  } mdu_div_op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } wired_div_state_t;

  localparam int WIRED_DIV_LATENCY = 34;

  // Conditional two's-complement negate; 0x8000_0000 maps to itself and is read as unsigned.
  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/wired_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, subtract if it fits.
module wired_div_step (
  input  logic [32:0] rem,
  input  logic [31:0] q,
  input  logic [31:0] divisor,
  output logic [32:0] rem_next,
  output logic [31:0] q_next
);

  logic [32:0] w_shifted;
  logic [32:0] w_divisor;
  logic        w_fits;

  assign w_shifted = {rem[31:0], q[31]};
  assign w_divisor = {1'b0, divisor};
  assign w_fits    = (w_shifted >= w_divisor);
  assign rem_next  = w_fits ? (w_shifted - w_divisor) : w_shifted;
  assign q_next    = {q[30:0], w_fits};

endmodule

// File: rtl/wired_div.sv
// Iterative 32-bit signed/unsigned divider with fixed 34-cycle latency, flush and
// valid/ready handshakes on both sides.
module wired_div
  import wired_div_pkg::*;
#(
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [31:0]      req_a_i,
  input  logic [31:0]      req_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_data_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             busy_o
);

  wired_div_state_t r_state;
  wired_div_state_t w_state_next;

  mdu_div_op_t      r_op;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [TAG_W-1:0] r_tag;
  logic             r_qsign;
  logic             r_rsign;
  logic [31:0]      r_div;
  logic [32:0]      r_rem;
  logic [31:0]      r_q;
  logic [4:0]       r_cnt;
  logic [31:0]      r_rsp_data;
  logic [TAG_W-1:0] r_rsp_tag;

  logic             w_accept;
  logic             w_is_signed;
  logic             w_is_mod;
  logic             w_sign_a;
  logic             w_sign_b;
  logic [32:0]      w_rem_next;
  logic [31:0]      w_q_next;
  logic [31:0]      w_q_fix;
  logic [31:0]      w_r_fix;
  logic [31:0]      w_result;

  assign w_accept    = req_valid_i & req_ready_o & ~flush_i;
  assign w_is_signed = (r_op == DIV_W) || (r_op == MOD_W);
  assign w_is_mod    = (r_op == MOD_W) || (r_op == MOD_WU);
  assign w_sign_a    = w_is_signed & r_a[31];
  assign w_sign_b    = w_is_signed & r_b[31];

  wired_div_step u_step (
    .rem      (r_rem),
    .q        (r_q),
    .divisor  (r_div),
    .rem_next (w_rem_next),
    .q_next   (w_q_next)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (req_valid_i) w_state_next = ST_PREP;
      ST_PREP: w_state_next = ST_ITER;
      ST_ITER: if (r_cnt == 5'd31) w_state_next = ST_FIX;
      ST_FIX:  w_state_next = ST_DONE;
      ST_DONE: if (rsp_ready_i) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    if (flush_i) w_state_next = ST_IDLE;
  end

  // Output decode
  always_comb begin
    req_ready_o = (r_state == ST_IDLE);
    busy_o      = (r_state != ST_IDLE);
    rsp_valid_o = (r_state == ST_DONE) & ~flush_i;
  end

  // Sign fix-up and special cases, evaluated while in FIX
  always_comb begin
    w_q_fix = cond_neg32(r_q, r_qsign);
    w_r_fix = cond_neg32(r_rem[31:0], r_rsign);
    if (r_b == 32'd0) begin
      w_q_fix = 32'hFFFF_FFFF;
      w_r_fix = r_a;
    end else if (w_is_signed && (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF)) begin
      w_q_fix = 32'h8000_0000;
      w_r_fix = 32'd0;
    end
    w_result = w_is_mod ? w_r_fix : w_q_fix;
  end

  // Operand latch, preparation and iteration datapath
  always_ff @(posedge clk) begin
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          r_op  <= mdu_div_op_t'(req_op_i);
          r_a   <= req_a_i;
          r_b   <= req_b_i;
          r_tag <= req_tag_i;
        end
      end
      ST_PREP: begin
        r_qsign <= w_sign_a ^ w_sign_b;
        r_rsign <= w_sign_a;
        r_q     <= cond_neg32(r_a, w_sign_a);
        r_div   <= cond_neg32(r_b, w_sign_b);
        r_rem   <= 33'd0;
        r_cnt   <= 5'd0;
      end
      ST_ITER: begin
        r_rem <= w_rem_next;
        r_q   <= w_q_next;
        r_cnt <= r_cnt + 5'd1;
      end
      default: ;
    endcase
  end

  // Response holding registers stay frozen throughout DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_data <= 32'd0;
      r_rsp_tag  <= '0;
    end else if (r_state == ST_FIX) begin
      r_rsp_data <= w_result;
      r_rsp_tag  <= r_tag;
    end
  end

  assign rsp_data_o = r_rsp_data;
  assign rsp_tag_o  = r_rsp_tag;

endmodule

// File: tb/tb_wired_div.sv
// Randomized self-checking bench for wired_div against an arithmetic reference model.
module tb_wired_div;
  import wired_div_pkg::*;

  localparam int TAG_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [1:0]       req_op_i;
  logic [31:0]      req_a_i;
  logic [31:0]      req_b_i;
  logic [TAG_W-1:0] req_tag_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [31:0]      rsp_data_o;
  logic [TAG_W-1:0] rsp_tag_o;
  logic             busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wired_div #(.TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_op_i    (req_op_i),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .req_tag_i   (req_tag_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_tag_o   (rsp_tag_o),
    .busy_o      (busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: op[1]=unsigned, op[0]=remainder; built from language division operators.
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[0] ? a : 32'hFFFF_FFFF;
    if (!op[1]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[0] ? 32'd0 : 32'h8000_0000;
      return op[0] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[0] ? (a % b) : (a / b);
  endfunction

  // Present a request and return #1 after the edge that accepted it.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag);
    int bound;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_a_i     = a;
    req_b_i     = b;
    req_tag_i   = tag;
    bound = 0;
    while (!req_ready_o && bound < 200) begin
      @(negedge clk);
      bound++;
    end
    if (bound >= 200) chk("accept_timeout", 64'(bound), 64'd0);
    @(posedge clk);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid_o && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] tag);
    int lat;
    rsp_ready_i = 1'b1;
    send(op, a, b, tag);
    wait_rsp(lat);
    chk({name, "_lat"}, 64'(lat), 64'(WIRED_DIV_LATENCY));
    chk({name, "_data"}, 64'(rsp_data_o), 64'(ref_res(op, a, b)));
    chk({name, "_tag"}, 64'(rsp_tag_o), 64'(tag));
    @(posedge clk);
    #1;
    chk({name, "_idle"}, {62'd0, req_ready_o, busy_o}, 64'b10);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return 32'd0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    int seen;
    logic [31:0]      held_data;
    logic [TAG_W-1:0] held_tag;
    logic             stable;

    rst = 1'b1;
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    req_op_i = 2'b00;
    req_a_i = '0;
    req_b_i = '0;
    req_tag_i = '0;
    rsp_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(req_ready_o), 64'd1);
    chk("rst_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_data", 64'(rsp_data_o), 64'd0);
    chk("rst_tag", 64'(rsp_tag_o), 64'd0);
    rst = 1'b0;

    run_op("divw_100_7", 2'b00, 32'd100, 32'd7, 6'd5);
    run_op("modw_m7_2", 2'b01, 32'hFFFF_FFF9, 32'd2, 6'd6);
    run_op("divw_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 6'd7);
    run_op("divwu_big", 2'b10, 32'hFFFF_FFFF, 32'h10, 6'd8);
    run_op("modwu_big", 2'b11, 32'hFFFF_FFFF, 32'h10, 6'd9);
    run_op("divw_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 6'd10);
    run_op("modw_ovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 6'd11);
    run_op("divwu_z", 2'b10, 32'd123, 32'd0, 6'd12);
    run_op("modwu_z", 2'b11, 32'd123, 32'd0, 6'd13);
    run_op("divw_negz", 2'b00, 32'hFFFF_FF00, 32'd0, 6'd14);
    run_op("modw_negz", 2'b01, 32'hFFFF_FF00, 32'd0, 6'd15);

    // Flush during ITER: the in-flight result must never appear
    send(2'b00, 32'd1000, 32'd3, 6'd33);
    repeat (11) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    chk("flush_iter_idle", {62'd0, req_ready_o, busy_o}, 64'b10);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (rsp_valid_o) seen++;
    end
    chk("flush_iter_novalid", 64'(seen), 64'd0);

    // Flush while DONE with consumer ready: no handshake, back to IDLE
    rsp_ready_i = 1'b0;
    send(2'b10, 32'd77, 32'd5, 6'd34);
    wait_rsp(lat);
    chk("flushdone_lat", 64'(lat), 64'(WIRED_DIV_LATENCY));
    @(negedge clk);
    flush_i = 1'b1;
    rsp_ready_i = 1'b1;
    #1 chk("flushdone_masked", 64'(rsp_valid_o), 64'd0);
    @(posedge clk);
    #1 flush_i = 1'b0;
    chk("flushdone_idle", {62'd0, req_ready_o, busy_o, rsp_valid_o}, 64'b100);

    // Backpressure for 20 cycles, then handshake and back-to-back request
    rsp_ready_i = 1'b0;
    send(2'b01, 32'hFFFF_FC18, 32'd7, 6'd40);
    wait_rsp(lat);
    chk("bp_lat", 64'(lat), 64'(WIRED_DIV_LATENCY));
    held_data = rsp_data_o;
    held_tag = rsp_tag_o;
    chk("bp_data", 64'(held_data), 64'(ref_res(2'b01, 32'hFFFF_FC18, 32'd7)));
    stable = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1 if (!rsp_valid_o || req_ready_o || rsp_data_o !== held_data || rsp_tag_o !== held_tag)
        stable = 1'b0;
    end
    chk("bp_stable", 64'(stable), 64'd1);
    @(negedge clk);
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1 chk("bp_handshake_idle", {62'd0, req_ready_o, rsp_valid_o}, 64'b10);
    send(2'b10, 32'd500, 32'd9, 6'd41);
    chk("b2b_busy", {62'd0, req_ready_o, busy_o}, 64'b01);
    wait_rsp(lat);
    chk("b2b_lat", 64'(lat), 64'(WIRED_DIV_LATENCY));
    chk("b2b_data", 64'(rsp_data_o), 64'(ref_res(2'b10, 32'd500, 32'd9)));
    chk("b2b_tag", 64'(rsp_tag_o), 64'd41);
    @(posedge clk);
    #1;

    // Randomized operations over all ops with biased corner operands
    for (int i = 0; i < 150; i++) begin
      logic [1:0]       op;
      logic [31:0]      a;
      logic [31:0]      b;
      logic [TAG_W-1:0] tag;
      op  = 2'($urandom_range(0, 3));
      a   = pick_operand();
      b   = pick_operand();
      tag = TAG_W'($urandom);
      run_op("rand", op, a, b, tag);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
